aer_spike_encoder: RTL and testbench
====================================

// Module: aer_spike_encoder
// PURPOSE
//  Downstream consumer of the Poisson spike generator during the per-timestep neuron scan.
//  - Aligns the scanned neuron address with the generator's registered spike output.
//  - Encodes each spike as an AER word and, at end of timestep, a marker word.
//  - Buffers the words in a FWFT FIFO and drives them out on a valid/ready interface.
// PARAMETERS
//  ADDR_LEN    8   neuron address width; AER word is ADDR_LEN+1 bits
//  FIFO_DEPTH  16  FIFO entries; power of two, >=4
//  SPIKE_LAT   1   cycles from scan_en/scan_addr sample to spike valid (>=1)
//  TS_LEN      8   timestep counter width; TS_LEN <= ADDR_LEN
//  DROP_LEN    16  dropped-event counter width
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   synchronous, active-high
//  scan_en    in   1                   neuron slot evaluated this cycle (same pulse as generator enable)
//  scan_addr  in   ADDR_LEN            address of that neuron
//  spike      in   1                   generator spike, SPIKE_LAT cycles after scan_en
//  ts_done    in   1                   1-cycle pulse: timestep scan finished
//  aer_valid  out  1                   FIFO head valid
//  aer_ready  in   1                   consumer accepts head
//  aer_data   out  ADDR_LEN+1          [ADDR_LEN]=0: spike, low bits=addr; =1: marker, low bits=ts_cnt zero-extended
//  fifo_level out  $clog2(FIFO_DEPTH)+1 current occupancy
//  drop_cnt   out  DROP_LEN            events dropped on full; saturates at all-ones
//  proto_err  out  1                   sticky: scan_en and ts_done high in same cycle
// BEHAVIOUR
//  Reset: aer_valid=0, fifo_level=0, drop_cnt=0, proto_err=0, ts_cnt=0, delay pipes cleared.
//  - Reset mid-operation discards FIFO contents and in-flight events.
//  Alignment pipeline:
//  - scan_en/scan_addr and ts_done each go through SPIKE_LAT register stages.
//  - en_d = delayed scan_en; addr_d = delayed scan_addr; ts_d = delayed ts_done.
//  - spike is ignored when en_d=0; the generator holds spike between enables.
//  Push request per cycle, at most one:
//  - event when en_d & spike: word {0,addr_d}.
//  - marker when ts_d: word {1,ts_cnt}.
//  Protocol violation:
//  - scan_en & ts_done in the same input cycle: ts_done dropped at input, proto_err set.
//  - Therefore event and marker never collide downstream.
//  Admission uses fifo_level at the start of the cycle; a same-cycle pop does not free space:
//  - event accepted iff level < FIFO_DEPTH-1 (last slot reserved for markers);
//    else drop_cnt+1 (saturating).
//  - marker accepted iff level < FIFO_DEPTH; else drop_cnt+1.
//  - ts_cnt increments (wraps mod 2^TS_LEN) on every ts_d, accepted or not.
//  FIFO:
//  - circular buffer, rd/wr pointers wrap mod FIFO_DEPTH.
//  - aer_valid = (level!=0); aer_data = head, first-word-fall-through.
//  - pop when aer_valid & aer_ready; aer_ready ignored when empty.
//  - simultaneous push+pop: level unchanged; data order preserved.
//  - aer_data stable while aer_valid & !aer_ready.
//  Latency (SPIKE_LAT=1, empty FIFO):
//  - scan_en at cycle 0 -> spike at cycle 1 -> aer_valid=1 with word at cycle 2.
//  Throughput: one push and one pop per cycle sustained.
// TESTING
//  1. scan_en cyc0 addr=0x2A, spike=1 cyc1 -> cyc2 aer_valid=1, aer_data=0x02A; ready=1 -> pops, valid=0 cyc3.
//  2. spike held 1 with scan_en=0 for 5 cycles -> no pushes, level stays 0.
//  3. ready=0, 20 spiking scans addr 0..19 -> addr 0..14 stored, level=15, drop_cnt=5;
//     then ts_done -> marker 0x100 takes slot 16, level=16.
//  4. Drain case 3 -> words 0x000..0x00E then 0x100 in order; next ts_done -> marker 0x101.
//  5. Full FIFO (level=16), ready=1 and marker pending same cycle -> marker dropped, drop_cnt+1, level=15.
//  6. scan_en & ts_done same cycle -> proto_err=1, no marker, ts_cnt unchanged; reset mid-burst -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/aer_spike_encoder_if.sv
// AER output bus: valid/ready handshake carrying spike and marker words.
interface aer_spike_encoder_if #(
    parameter int ADDR_LEN = 8
);
    logic                aer_valid;
    logic                aer_ready;
    logic [ADDR_LEN:0]   aer_data;

    modport master (
        output aer_valid,
        output aer_data,
        input  aer_ready
    );

    modport slave (
        input  aer_valid,
        input  aer_data,
        output aer_ready
    );
endinterface

// File: rtl/aer_spike_encoder.sv
// AER spike encoder: aligns the scanned neuron address with the spike
// generator output, encodes spikes and end-of-timestep markers as AER words,
// and buffers them in a first-word-fall-through FIFO.
module aer_spike_encoder #(
    parameter int ADDR_LEN   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SPIKE_LAT  = 1,
    parameter int TS_LEN     = 8,
    parameter int DROP_LEN   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           scan_en,
    input  logic [ADDR_LEN-1:0]            scan_addr,
    input  logic                           spike,
    input  logic                           ts_done,
    aer_spike_encoder_if.master            aer,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [DROP_LEN-1:0]            drop_cnt,
    output logic                           proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // The last FIFO slot is kept free for markers so a full burst of spikes
    // can never hide the end of a timestep from the consumer.
    localparam logic [LVL_W-1:0] EVT_LIMIT = LVL_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] MRK_LIMIT = LVL_W'(FIFO_DEPTH);

    logic                en_pipe   [SPIKE_LAT];
    logic [ADDR_LEN-1:0] addr_pipe [SPIKE_LAT];
    logic                ts_pipe   [SPIKE_LAT];

    logic [ADDR_LEN:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [TS_LEN-1:0]   ts_cnt;

    logic                ts_in;
    logic                en_d;
    logic [ADDR_LEN-1:0] addr_d;
    logic                ts_d;
    logic                evt_req;
    logic                evt_ok;
    logic                mrk_ok;
    logic                push;
    logic                pop;
    logic                drop;
    logic [ADDR_LEN:0]   push_word;

    // A ts_done that collides with a scan is discarded here, so event and
    // marker requests can never meet in the same downstream cycle.
    assign ts_in  = ts_done & ~scan_en;

    assign en_d   = en_pipe[SPIKE_LAT-1];
    assign addr_d = addr_pipe[SPIKE_LAT-1];
    assign ts_d   = ts_pipe[SPIKE_LAT-1];

    // Delay scan enable, address and timestep pulse to line up with the spike.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SPIKE_LAT; i++) begin
                en_pipe[i]   <= 1'b0;
                addr_pipe[i] <= '0;
                ts_pipe[i]   <= 1'b0;
            end
        end else begin
            en_pipe[0]   <= scan_en;
            addr_pipe[0] <= scan_addr;
            ts_pipe[0]   <= ts_in;
            for (int i = 1; i < SPIKE_LAT; i++) begin
                en_pipe[i]   <= en_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                ts_pipe[i]   <= ts_pipe[i-1];
            end
        end
    end

    // Admission decisions use the occupancy at the start of the cycle only;
    // a pop in the same cycle does not make room for the incoming word.
    always_comb begin
        evt_req   = en_d & spike;
        evt_ok    = evt_req & (fifo_level < EVT_LIMIT);
        mrk_ok    = ts_d & (fifo_level < MRK_LIMIT);
        push      = evt_ok | mrk_ok;
        drop      = (evt_req & ~evt_ok) | (ts_d & ~mrk_ok);
        pop       = aer.aer_valid & aer.aer_ready;
        push_word = {1'b0, addr_d};
        if (ts_d) begin
            push_word = {1'b1, ADDR_LEN'(ts_cnt)};
        end
    end

    // FIFO storage; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers, occupancy, timestep counter, drop counter and protocol flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            ts_cnt     <= '0;
            drop_cnt   <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (ts_d) begin
                ts_cnt <= ts_cnt + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (scan_en && ts_done) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign aer.aer_valid = (fifo_level != '0);
    assign aer.aer_data  = mem[rd_ptr];

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Self-checking bench for aer_spike_encoder: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_aer_spike_encoder;

    localparam int ADDR_LEN   = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int TS_LEN     = 8;
    localparam int DROP_LEN   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                scan_en;
    logic [ADDR_LEN-1:0] scan_addr;
    logic                spike;
    logic                ts_done;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [DROP_LEN-1:0] drop_cnt;
    logic                proto_err;

    aer_spike_encoder_if #(.ADDR_LEN(ADDR_LEN)) aer_bus ();

    aer_spike_encoder #(
        .ADDR_LEN  (ADDR_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .SPIKE_LAT (1),
        .TS_LEN    (TS_LEN),
        .DROP_LEN  (DROP_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_en   (scan_en),
        .scan_addr (scan_addr),
        .spike     (spike),
        .ts_done   (ts_done),
        .aer       (aer_bus.master),
        .fifo_level(fifo_level),
        .drop_cnt  (drop_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: the FIFO is a queue, counters are plain integers.
    logic [ADDR_LEN:0]   m_q [$];
    int                  m_drop = 0;
    int                  m_ts   = 0;
    bit                  m_err  = 1'b0;
    bit                  p_en   = 1'b0;
    logic [ADDR_LEN-1:0] p_addr = '0;
    bit                  p_ts   = 1'b0;
    int                  m_lvl;
    bit                  m_push;
    logic [ADDR_LEN:0]   m_word;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: inputs change on the falling edge.
    task automatic applyStimulus(input bit en, input logic [ADDR_LEN-1:0] addr,
                                 input bit spk, input bit ts, input bit rdy);
        scan_en           = en;
        scan_addr         = addr;
        spike             = spk;
        ts_done           = ts;
        aer_bus.aer_ready = rdy;
        @(negedge clk);
    endtask

    // Model update: the spike belongs to the scan issued one cycle earlier.
    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_drop = 0;
            m_ts   = 0;
            m_err  = 1'b0;
            p_en   = 1'b0;
            p_addr = '0;
            p_ts   = 1'b0;
        end else begin
            m_lvl  = m_q.size();
            m_push = 1'b0;
            m_word = '0;
            if (p_en && spike) begin
                if (m_lvl < FIFO_DEPTH - 1) begin
                    m_push = 1'b1;
                    m_word = {1'b0, p_addr};
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (p_ts) begin
                if (m_lvl < FIFO_DEPTH) begin
                    m_push = 1'b1;
                    m_word = {1'b1, 8'(m_ts)};
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                m_ts = (m_ts + 1) % (1 << TS_LEN);
            end
            if (aer_bus.aer_ready && m_lvl > 0) begin
                void'(m_q.pop_front());
            end
            if (m_push) begin
                m_q.push_back(m_word);
            end
            if (scan_en && ts_done) begin
                m_err = 1'b1;
            end
            p_en   = scan_en;
            p_addr = scan_addr;
            p_ts   = ts_done && !scan_en;
        end
    end

    // Every cycle, compare all outputs with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_valid", 32'(aer_bus.aer_valid), 32'(m_q.size() != 0));
            checkOutput("model_level", 32'(fifo_level), 32'(m_q.size()));
            checkOutput("model_drop",  32'(drop_cnt), 32'(m_drop));
            checkOutput("model_err",   32'(proto_err), 32'(m_err));
            if (m_q.size() != 0) begin
                checkOutput("model_data", 32'(aer_bus.aer_data), 32'(m_q[0]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_valid", 32'(aer_bus.aer_valid), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_drop",  32'(drop_cnt), 32'd0);
        checkOutput("rst_err",   32'(proto_err), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Single spike latency and pop.
        applyStimulus(1, 8'h2A, 0, 0, 1);
        applyStimulus(0, 8'h00, 1, 0, 1);
        checkOutput("lat_valid", 32'(aer_bus.aer_valid), 32'd1);
        checkOutput("lat_data",  32'(aer_bus.aer_data), 32'h02A);
        applyStimulus(0, 8'h00, 1, 0, 1);
        checkOutput("pop_valid", 32'(aer_bus.aer_valid), 32'd0);

        // Held spike without scans must not push anything.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 1);
            checkOutput("hold_level", 32'(fifo_level), 32'd0);
        end

        // Burst of 20 spikes into a stalled FIFO, then a marker.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'(i), 1, 0, 0);
        end
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("burst_level", 32'(fifo_level), 32'd15);
        checkOutput("burst_drop",  32'(drop_cnt), 32'd5);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("marker_level", 32'(fifo_level), 32'd16);

        // Drain in order, then the next marker carries ts 1.
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_data", 32'(aer_bus.aer_data), (i < 15) ? 32'(i) : 32'h100);
            applyStimulus(0, 8'h00, 0, 0, 1);
        end
        checkOutput("drain_level", 32'(fifo_level), 32'd0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("marker2_data", 32'(aer_bus.aer_data), 32'h101);
        applyStimulus(0, 8'h00, 0, 0, 1);

        // Fill completely, then a marker arrives while full and popping.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 8'(i + 100), 1, 0, 0);
        end
        applyStimulus(0, 8'h00, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("full_level", 32'(fifo_level), 32'd16);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("fulldrop_level", 32'(fifo_level), 32'd15);
        checkOutput("fulldrop_drop",  32'(drop_cnt), 32'd6);

        // Drain, then a colliding scan/ts_done must leave ts_cnt alone.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 8'h00, 0, 0, 1);
        end
        applyStimulus(1, 8'h55, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("proto_err", 32'(proto_err), 32'd1);
        checkOutput("proto_level", 32'(fifo_level), 32'd0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("proto_marker", 32'(aer_bus.aer_data), 32'h104);

        // Reset in the middle of a burst.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 8'(i), 1, 0, 0);
        end
        reset = 1'b1;
        applyStimulus(1, 8'h07, 1, 0, 0);
        checkOutput("midrst_valid", 32'(aer_bus.aer_valid), 32'd0);
        checkOutput("midrst_level", 32'(fifo_level), 32'd0);
        checkOutput("midrst_drop",  32'(drop_cnt), 32'd0);
        checkOutput("midrst_err",   32'(proto_err), 32'd0);
        reset = 1'b0;
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("postrst_level", 32'(fifo_level), 32'd0);

        // Randomized traffic with occasional collisions and resets.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 999) < 2);
            applyStimulus($urandom_range(0, 1) == 1, 8'($urandom),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 25));
        end
        reset = 1'b0;
        applyStimulus(0, 8'h00, 0, 0, 1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
